// File: rtl/apb_reg_pkg.sv
// Shared definitions for the APB-to-register bridge.
//   state_t     : bridge FSM encoding (IDLE, REQ, RESP, DRAIN)
//   ALIGN_MASK  : address bits that must be zero for an aligned word access
//   ctr_width() : width of a timeout counter that must hold 0..cycles
package apb_reg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Never returns 0 so a disabled timeout (cycles = 0) still gets a legal vector.
  function automatic int ctr_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Saturating wait-cycle counter with an expiry flag, shared by bus bridges.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the count to 0 (has priority over enable)
//   enable     : count this cycle
//   expired    : high during an enabled cycle that is the last one allowed,
//                i.e. count == TIMEOUT_CYCLES-1; never high when TIMEOUT_CYCLES = 0
module bridge_timeout_ctr
  import apb_reg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = ctr_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Saturates at TIMEOUT_CYCLES so it can never wrap back into range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (TIMEOUT_CYCLES == 0)) begin
      count <= '0;
    end else if (enable && (count != SAT)) begin
      count <= count + CW'(1);
    end
  end

  assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_reg_bridge.sv
// APB completer that turns each APB transfer into one register_if request.
//   APB side      : PCLK, PRESETn, PADDR, PWDATA, PWRITE, PSEL, PENABLE in;
//                   PRDATA, PREADY, PSLVERR out (all registered)
//   register side : REG_ADDR, REG_WDATA, REG_VALID, REG_READ, REG_WRITE out
//                   (all registered); REG_RDATA, REG_ACK, REG_ERROR in
//   dbg_state     : current FSM state, for observation only
//
// Handshake: a register request is REG_VALID=1 with REG_READ/REG_WRITE,
// REG_ADDR and REG_WDATA held stable until the cycle REG_ACK is sampled high;
// REG_RDATA and REG_ERROR are meaningful only in that ACK cycle. On the APB
// side PREADY is a single-cycle pulse and PSLVERR/PRDATA are meaningful only
// while PREADY=1 (PRDATA is 0 otherwise). A request unanswered for
// TIMEOUT_CYCLES REQ cycles is withdrawn and reported as PSLVERR.
module apb_reg_bridge
  import apb_reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PWRITE,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [ADDR_WIDTH-1:0] REG_ADDR,
  output logic [DATA_WIDTH-1:0] REG_WDATA,
  output logic                  REG_VALID,
  output logic                  REG_READ,
  output logic                  REG_WRITE,
  input  logic [DATA_WIDTH-1:0] REG_RDATA,
  input  logic                  REG_ACK,
  input  logic                  REG_ERROR,
  output state_t                dbg_state
);

  state_t state;
  logic   abandoned;  // PSEL seen low during REQ: finish the request, drop the reply
  logic   expired;

  bridge_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (state == IDLE),
    .enable  (state == REQ),
    .expired (expired)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      abandoned <= 1'b0;
      PRDATA    <= '0;
      PREADY    <= 1'b0;
      PSLVERR   <= 1'b0;
      REG_ADDR  <= '0;
      REG_WDATA <= '0;
      REG_VALID <= 1'b0;
      REG_READ  <= 1'b0;
      REG_WRITE <= 1'b0;
    end else begin
      // APB response outputs are single-cycle unless set below.
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;

      case (state)
        IDLE: begin
          // Only a setup phase starts a transfer; a bare access phase is ignored.
          if (PSEL && !PENABLE) begin
            abandoned <= 1'b0;
            if ((PADDR[1:0] & ALIGN_MASK) != 2'b00) begin
              state   <= RESP;
              PREADY  <= 1'b1;
              PSLVERR <= 1'b1;
            end else begin
              state     <= REQ;
              REG_ADDR  <= PADDR;
              REG_WDATA <= PWDATA;
              REG_VALID <= 1'b1;
              REG_READ  <= ~PWRITE;
              REG_WRITE <= PWRITE;
            end
          end
        end

        REQ: begin
          if (!PSEL) begin
            abandoned <= 1'b1;
          end
          // ACK is tested first so it wins over a same-cycle expiry.
          if (REG_ACK || expired) begin
            REG_VALID <= 1'b0;
            REG_READ  <= 1'b0;
            REG_WRITE <= 1'b0;
            if (abandoned || !PSEL) begin
              state <= DRAIN;
            end else begin
              state  <= RESP;
              PREADY <= 1'b1;
              if (REG_ACK) begin
                PSLVERR <= REG_ERROR;
                PRDATA  <= (REG_READ && !REG_ERROR) ? REG_RDATA : '0;
              end else begin
                PSLVERR <= 1'b1;
              end
            end
          end
        end

        RESP:    state <= IDLE;
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: doc/apb_reg_bridge.md
Name: apb_reg_bridge

Overview:
- APB completer (responder) that converts each APB transfer into exactly one register_if request on its initiator side.
- Sits between the system APB fabric and a peripheral register block.
- Adds wait states until the register block sends ACK.
- Generates PSLVERR on a register ERROR, on a misaligned address, or when a programmable ACK timeout expires.

Parameters:
- ADDR_WIDTH, 32, APB and register address width.
- DATA_WIDTH, 32, APB and register data width (multiple of 8).
- TIMEOUT_CYCLES, 64, maximum number of REQ cycles without ACK before the bridge aborts; 0 disables the timeout.

Ports:
- PCLK  input  1  clock, shared by both sides.
- PRESETn  input  1  reset; asynchronous, active-low.
- PADDR  input  ADDR_WIDTH  APB address.
- PWDATA  input  DATA_WIDTH  APB write data.
- PWRITE  input  1  APB direction; 1 = write.
- PSEL  input  1  APB select.
- PENABLE  input  1  APB access phase.
- PRDATA  output  DATA_WIDTH  APB read data.
- PREADY  output  1  APB transfer complete.
- PSLVERR  output  1  APB error, valid with PREADY.
- REG_ADDR  output  ADDR_WIDTH  register address.
- REG_WDATA  output  DATA_WIDTH  register write data.
- REG_VALID  output  1  register request valid.
- REG_READ  output  1  read request.
- REG_WRITE  output  1  write request.
- REG_RDATA  input  DATA_WIDTH  register read data, valid with ACK.
- REG_ACK  input  1  one-cycle completion pulse.
- REG_ERROR  input  1  error flag, valid with ACK.

Behaviour:
- Clocking and reset: one clock, PCLK. PRESETn is asynchronous, active-low. While PRESETn = 0:
  - all outputs are 0;
  - the FSM is in IDLE;
  - the timeout counter is 0.
- FSM states: IDLE, REQ, RESP, DRAIN. All outputs are registered.
- IDLE:
  - On the cycle T where PSEL=1 and PENABLE=0, capture PADDR, PWDATA and PWRITE.
  - If PADDR[1:0] != 0: go to RESP with err=1 and rdata=0, and issue no register request.
  - Otherwise go to REQ. At T+1 drive REG_VALID=1, REG_READ=~PWRITE, REG_WRITE=PWRITE, plus the captured address and data.
- REQ:
  - REG_VALID and the other REG_* outputs are held stable until REG_ACK is sampled high.
  - The timeout counter increments each REQ cycle.
  - On REG_ACK: capture REG_RDATA (reads only; writes capture 0) and REG_ERROR, drop REG_VALID/READ/WRITE at the next edge, and go to RESP.
  - On timeout (counter reaches TIMEOUT_CYCLES-1 without ACK): drop the request, capture err=1 and rdata=0, and go to RESP.
  - An ACK arriving in the same cycle as the timeout wins; the transfer completes normally.
- RESP:
  - PREADY=1 for exactly one cycle; PSLVERR=err; PRDATA=rdata.
  - PRDATA is 0 whenever PREADY=0.
  - Next state is IDLE. A back-to-back setup phase in the following cycle is accepted with no bubble beyond the protocol minimum.
- Latency:
  - Minimum transfer (ACK sampled in the first REQ cycle): setup at T, PREADY at T+2, giving 1 wait state.
  - Each extra cycle of ACK delay adds one wait state.
- PSEL dropping in REQ (protocol violation): the register request still completes to ACK or timeout. The FSM then goes through DRAIN (one cycle, PREADY=0) to IDLE, and the response is discarded.
- PENABLE=1 seen in IDLE without a preceding setup phase: ignored, no response.
- REG_ACK seen outside REQ: ignored.
- Reset mid-operation: everything aborts immediately, with REG_VALID and PREADY forced to 0 asynchronously. No response is issued after reset release.
- Widths:
  - The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
  - It clears on entry to REQ.
  - With TIMEOUT_CYCLES = 0 the counter is held at 0.

Decomposition:
- Shared package apb_reg_pkg:
  - state enum (IDLE, REQ, RESP, DRAIN);
  - localparam for the alignment mask;
  - function computing the counter width.
- One sub-module, bridge_timeout_ctr: enable, clear, expired flag, TIMEOUT_CYCLES parameter, zero meaning disabled. It is reusable by future AXI bridges.

Test Plan:
- Read, ACK on first REQ cycle: PADDR=0x10, REG_RDATA=0xDEADBEEF -> REG_READ=1 for one cycle; PREADY at T+2 with PRDATA=0xDEADBEEF and PSLVERR=0.
- Write with ACK delayed 5 cycles: PADDR=0x24, PWDATA=0xA5A5_0001 -> REG_* held stable for 5 cycles; PREADY after 6 wait states with PSLVERR=0.
- REG_ERROR=1 with ACK on a read -> PSLVERR=1 and PRDATA=0.
- No ACK, TIMEOUT_CYCLES=8 -> REG_VALID deasserts after 8 REQ cycles; PREADY=1 with PSLVERR=1. A late ACK afterwards is ignored.
- Misaligned PADDR=0x13 -> no REG_VALID; PREADY at T+1 with PSLVERR=1.
- Back-to-back write then read, and PRESETn asserted during REQ -> both transfers complete without extra bubbles; reset forces all outputs to 0 at once, and the next transfer after release works normally.
